// File: rtl/sub_pkg.sv
// sub_pkg: shared widths and types for the frame-based subtractor datapath.
package sub_pkg;
   localparam int SUB_DATA_W    = 8;
   localparam int SUB_FRAME_LEN = 8;
   localparam int SUB_FC_W      = 3;
   typedef logic [SUB_DATA_W-1:0] sub_data_t;
endpackage

// File: rtl/sub_sync_fifo.sv
// sub_sync_fifo: show-ahead synchronous FIFO; push while full succeeds only with a same-cycle pop.
module sub_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          wr_en, rd_en;
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign full  = level == LVL_W'(DEPTH);
   assign empty = level == '0;
   assign dout  = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LVL_W'(wr_en) - LVL_W'(rd_en);
      end
   end
endmodule

// File: rtl/sub_result_fifo.sv
// sub_result_fifo: captures one subtractor result per 8-cycle frame into a valid/ready FIFO.
// Optional saturating drop counter enabled by SUB_RES_DROP_CNT_EN.
module sub_result_fifo
   import sub_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SUB_DATA_W-1:0] result,
   output logic [SUB_DATA_W-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  full,
   output logic                  empty,
   output logic [LVL_W-1:0]      level
`ifdef SUB_RES_DROP_CNT_EN
  ,output logic [7:0]            drop_cnt
`endif
);
   logic [SUB_FC_W-1:0] fc;
   logic                primed, cap, pop;
   // The first frame after reset carries an undefined upstream result, so capture waits for primed.
   assign cap     = fc == '0 && primed && !rst;
   assign m_valid = !empty;
   assign pop     = m_valid && m_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         fc     <= '0;
         primed <= 1'b0;
      end else begin
         fc <= fc + 1'b1;
         if (fc == SUB_FC_W'(SUB_FRAME_LEN - 1)) primed <= 1'b1;
      end
   end
   sub_sync_fifo #(.DEPTH(DEPTH), .W(SUB_DATA_W), .LVL_W(LVL_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cap),
      .pop   (pop),
      .din   (result),
      .dout  (m_data),
      .full  (full),
      .empty (empty),
      .level (level)
   );
`ifdef SUB_RES_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) drop_cnt <= '0;
      else if (cap && full && !pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
   end
`endif
endmodule

// File: tb/tb_sub_result_fifo.sv
// tb_sub_result_fifo: directed scenarios plus random traffic against a queue-based frame model.
module tb_sub_result_fifo;
   logic       clk = 1'b0, rst = 1'b1, m_ready = 1'b0;
   logic [7:0] result = 8'h00, m_data;
   logic       m_valid, full, empty;
   logic [2:0] level;
`ifdef SUB_RES_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif
   int checks = 0, errors = 0;

   sub_result_fifo #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .result(result), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .full(full), .empty(empty), .level(level)
`ifdef SUB_RES_DROP_CNT_EN
     ,.drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference: t counts clean edges since reset; a capture is every 8th edge skipping the first frame.
   logic [7:0] q[$];
   int t = 0, drops = 0;
   always @(posedge clk) begin
      if (rst) begin
         t = 0;
         q.delete();
         drops = 0;
      end else begin
         if (q.size() > 0 && m_ready) void'(q.pop_front());
         if (t % 8 == 0 && t >= 8) begin
            if (q.size() < 4) q.push_back(result);
            else if (drops < 255) drops++;
         end
         t++;
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic goto_cap();
      int n = 0;
      while (!(t % 8 == 0 && t >= 8) && n < 40) begin step(); n++; end
      checks++;
      if (n >= 40) begin errors++; $display("FAIL goto_cap: no capture slot after %0d cycles", n); end
   endtask

   task automatic test_reset();
      rst = 1'b1; m_ready = 1'b0;
      step(); step();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset m_valid got %b exp 0", m_valid); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset m_data got %h exp 00", m_data); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset full got %b exp 0", full); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset level got %0d exp 0", level); end
`ifdef SUB_RES_DROP_CNT_EN
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset drop_cnt got %0d exp 0", drop_cnt); end
`endif
   endtask

   task automatic test_first_frame();
      rst = 1'b0; result = 8'h02;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL first_frame m_valid cyc %0d got %b exp 0", i, m_valid); end
      end
   endtask

   task automatic test_basic();
      logic [7:0] a = 8'd5, b = 8'd3;
      goto_cap();
      result = a - b;
      step();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic m_valid got %b exp 1", m_valid); end
      checks++; if (m_data !== 8'h02) begin errors++; $display("FAIL basic m_data got %h exp 02", m_data); end
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic level got %0d exp 1", level); end
      m_ready = 1'b1; step(); m_ready = 1'b0;
      checks++; if (empty !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL basic drain empty %b m_valid %b exp 1 0", empty, m_valid); end
   endtask

   task automatic test_negative();
      logic [7:0] a[2] = '{8'h03, 8'h80};
      logic [7:0] b[2] = '{8'h05, 8'h01};
      logic [7:0] e[2] = '{8'hFE, 8'h7F};
      for (int i = 0; i < 2; i++) begin
         goto_cap();
         result = a[i] - b[i];
         step();
         checks++; if (m_data !== e[i]) begin errors++; $display("FAIL negative[%0d] m_data got %h exp %h", i, m_data, e[i]); end
         m_ready = 1'b1; step(); m_ready = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      for (int v = 1; v <= 5; v++) begin goto_cap(); result = 8'(v); step(); end
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp level got %0d exp 4", level); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL bp full got %b exp 1", full); end
`ifdef SUB_RES_DROP_CNT_EN
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp drop_cnt got %0d exp 1", drop_cnt); end
`endif
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (m_data !== 8'(i + 1)) begin errors++; $display("FAIL bp drain[%0d] got %h exp %h", i, m_data, 8'(i + 1)); end
         step();
      end
      m_ready = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp empty after drain got %b exp 1", empty); end
   endtask

   task automatic test_full_pop();
      for (int v = 10; v <= 13; v++) begin goto_cap(); result = 8'(v); step(); end
      goto_cap();
      result = 8'd14; m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_pop level got %0d exp 4", level); end
      checks++; if (m_data !== 8'd11) begin errors++; $display("FAIL full_pop head got %h exp 0b", m_data); end
`ifdef SUB_RES_DROP_CNT_EN
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_pop drop_cnt got %0d exp 1", drop_cnt); end
`endif
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (m_data !== 8'(11 + i)) begin errors++; $display("FAIL full_pop drain[%0d] got %h exp %h", i, m_data, 8'(11 + i)); end
         step();
      end
      m_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      for (int v = 20; v <= 21; v++) begin goto_cap(); result = 8'(v); step(); end
      goto_cap();
      result = 8'd22; rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_reset level got %0d exp 0", level); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset m_valid got %b exp 0", m_valid); end
`ifdef SUB_RES_DROP_CNT_EN
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset drop_cnt got %0d exp 0", drop_cnt); end
`endif
      for (int i = 0; i < 8; i++) step();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset early capture m_valid got %b exp 0", m_valid); end
      step();
      checks++; if (m_valid !== 1'b1 || m_data !== 8'd22) begin errors++; $display("FAIL mid_reset capture m_valid %b m_data %h exp 1 16", m_valid, m_data); end
   endtask

   task automatic test_random();
      logic [7:0] exp_data;
      for (int i = 0; i < 800; i++) begin
         exp_data = q.size() > 0 ? q[0] : 8'h00;
         checks++; if (m_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand[%0d] m_valid got %b exp %b", i, m_valid, q.size() > 0); end
         checks++; if (m_data !== exp_data) begin errors++; $display("FAIL rand[%0d] m_data got %h exp %h", i, m_data, exp_data); end
         checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rand[%0d] level got %0d exp %0d", i, level, q.size()); end
         checks++; if (full !== (q.size() == 4) || empty !== (q.size() == 0)) begin errors++; $display("FAIL rand[%0d] full/empty got %b%b exp %b%b", i, full, empty, q.size() == 4, q.size() == 0); end
`ifdef SUB_RES_DROP_CNT_EN
         checks++; if (drop_cnt !== 8'(drops)) begin errors++; $display("FAIL rand[%0d] drop_cnt got %0d exp %0d", i, drop_cnt, drops); end
`endif
         result  = 8'($urandom);
         m_ready = $urandom_range(0, 15) == 0;
         rst     = $urandom_range(0, 299) == 0;
         step();
      end
      rst = 1'b0; m_ready = 1'b0;
   endtask

   initial begin
      step();
      test_reset();
      test_first_frame();
      test_basic();
      test_negative();
      test_backpressure();
      test_full_pop();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
